wptr_full_level: RTL and testbench

//  Write-clock-domain pointer and status generator for the async FIFO; successor to the basic

---
 rtl/wptr_full_level.sv | 89 ++++++++
 tb/tb_wptr_full_level.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wptr_full_level.sv
// Write-domain pointer and status for the async FIFO: Gray write pointer, full,
// almost-full against a programmable threshold, fill level and a sticky overflow flag.
module wptr_full_level #(
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic             clr_ovf,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             awfull,
  output logic [ASIZE:0]   wlevel,
  output logic             wovf
);

  localparam logic [ASIZE:0] DEPTH = (ASIZE+1)'(2**ASIZE);

  logic [ASIZE:0] wbin_q,   wbin_d;
  logic [ASIZE:0] wptr_q,   wptr_d;
  logic [ASIZE:0] wlevel_q, wlevel_d;
  logic           wfull_q,  wfull_d;
  logic           awfull_q, awfull_d;
  logic           wovf_q,   wovf_d;

  logic [ASIZE:0] rbin;
  logic [ASIZE:0] thr_eff;
  logic           accept;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  always_comb begin
    thr_eff = afull_thresh;
    if (afull_thresh > DEPTH) begin
      thr_eff = DEPTH;
    end
  end

  // Acceptance uses the registered full flag, so a write in the cycle full rises is refused.
  always_comb begin
    accept   = winc & ~wfull_q;
    wbin_d   = wbin_q + {{ASIZE{1'b0}}, accept};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    wlevel_d = wbin_d - rbin;
    wfull_d  = (wlevel_d == DEPTH);
    awfull_d = (wlevel_d >= thr_eff);
    wovf_d   = wovf_q;
    if (winc & wfull_q) begin
      wovf_d = 1'b1;
    end else if (clr_ovf) begin
      wovf_d = 1'b0;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr  = wbin_q[ASIZE-1:0];
  assign wptr   = wptr_q;
  assign wlevel = wlevel_q;
  assign wfull  = wfull_q;
  assign awfull = awfull_q;
  assign wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Bench for wptr_full_level (ASIZE=4): directed vector table, hand-written corner
// sequences and a randomized run against an arithmetic reference model.
module tb_wptr_full_level;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic [4:0] afull_thresh;
  logic       clr_ovf;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       awfull;
  logic [4:0] wlevel;
  logic       wovf;

  wptr_full_level #(.ASIZE(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .afull_thresh(afull_thresh), .clr_ovf(clr_ovf), .waddr(waddr), .wptr(wptr),
    .wfull(wfull), .awfull(awfull), .wlevel(wlevel), .wovf(wovf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int total  = 0;
  int passed = 0;

  int m_wbin, m_rbin, m_level;
  bit m_full, m_afull, m_ovf;

  typedef struct {
    bit w; bit c; bit ri; int th;
    int e_wbin; int e_level; bit e_full; bit e_af; bit e_ovf;
  } vec_t;
  vec_t vecs[$];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic logic [4:0] gray5(int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic void add(bit w, bit c, bit ri, int th, int e_wbin, int e_level,
                              bit e_full, bit e_af, bit e_ovf);
    vec_t v;
    v.w = w; v.c = c; v.ri = ri; v.th = th;
    v.e_wbin = e_wbin; v.e_level = e_level; v.e_full = e_full; v.e_af = e_af; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  function automatic void model_reset();
    m_wbin = 0; m_rbin = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
  endfunction

  // One clock: drive inputs, update the model at the edge, compare just after it.
  task automatic step(input bit w, input bit c, input int r, input int th);
    int thr;
    winc = w; clr_ovf = c; wq2_rptr = gray5(r); afull_thresh = 5'(th);
    @(posedge wclk);
    if (w && m_full) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (w && !m_full) m_wbin = (m_wbin + 1) % 32;
    m_rbin  = r;
    m_level = (m_wbin - m_rbin + 32) % 32;
    m_full  = (m_level == 16);
    thr     = (th > 16) ? 16 : th;
    m_afull = (m_level >= thr);
    #1;
    chk("wlevel", int'(wlevel), m_level);
    chk("wfull",  int'(wfull),  int'(m_full));
    chk("awfull", int'(awfull), int'(m_afull));
    chk("wovf",   int'(wovf),   int'(m_ovf));
    chk("wptr",   int'(wptr),   int'(gray5(m_wbin)));
    chk("waddr",  int'(waddr),  m_wbin % 16);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_wlevel"}, int'(wlevel), 0);
    chk({tag, "_wfull"},  int'(wfull),  0);
    chk({tag, "_awfull"}, int'(awfull), 0);
    chk({tag, "_wovf"},   int'(wovf),   0);
    chk({tag, "_wptr"},   int'(wptr),   0);
    chk({tag, "_waddr"},  int'(waddr),  0);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0; winc = 0; clr_ovf = 0; wq2_rptr = '0; afull_thresh = '0;
    repeat (2) @(negedge wclk);
    check_all_zero("reset");
    wrst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int rb;
    int th;
    bit w, ri, c;

    // Fill to full with threshold 12, retune threshold, overflow, clear, drain one, refill.
    for (int i = 0; i < 13; i++) add(1, 0, 0, 12, i + 1, i + 1, 0, (i + 1) >= 12, 0);
    add(0, 0, 0, 14, 13, 13, 0, 0, 0);
    add(1, 0, 0, 14, 14, 14, 0, 1, 0);
    add(1, 0, 0, 14, 15, 15, 0, 1, 0);
    add(1, 0, 0, 14, 16, 16, 1, 1, 0);
    add(1, 0, 0, 14, 16, 16, 1, 1, 1);
    add(1, 1, 0, 14, 16, 16, 1, 1, 1);
    add(0, 1, 0, 14, 16, 16, 1, 1, 0);
    add(0, 0, 1, 14, 16, 15, 0, 1, 0);
    add(1, 0, 0, 14, 17, 16, 1, 1, 0);

    do_reset();
    rb = 0;
    foreach (vecs[k]) begin
      if (vecs[k].ri) rb = rb + 1;
      step(vecs[k].w, vecs[k].c, rb, vecs[k].th);
      chk("tbl_wlevel", int'(wlevel), vecs[k].e_level);
      chk("tbl_wfull",  int'(wfull),  int'(vecs[k].e_full));
      chk("tbl_awfull", int'(awfull), int'(vecs[k].e_af));
      chk("tbl_wovf",   int'(wovf),   int'(vecs[k].e_ovf));
      chk("tbl_wptr",   int'(wptr),   int'(gray5(vecs[k].e_wbin)));
      chk("tbl_waddr",  int'(waddr),  vecs[k].e_wbin % 16);
    end

    // Pointer wrap: walk wbin to 31 keeping the FIFO nearly empty.
    do_reset();
    for (int i = 0; i < 31; i++) step(1, 0, m_wbin, 12);
    chk("wrap_wbin31_wptr", int'(wptr), int'(gray5(31)));
    step(0, 0, 20, 12);
    chk("wrap_level11", int'(wlevel), 11);
    step(1, 0, 20, 12);
    chk("wrap_waddr0",  int'(waddr),  0);
    chk("wrap_level12", int'(wlevel), 12);
    chk("wrap_full0",   int'(wfull),  0);
    chk("wrap_awfull1", int'(awfull), 1);

    // Zero threshold, then async reset with no clock edge.
    do_reset();
    step(0, 0, 0, 0);
    chk("thr0_awfull_first_edge", int'(awfull), 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("pre_reset_level5", int'(wlevel), 5);
    #2 wrst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge wclk);
    wrst_n = 1'b1;
    model_reset();

    // Randomized traffic, including thresholds above DEPTH.
    th = 31;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 31) == 0) th = $urandom_range(0, 31);
      if ((n / 250) % 2 == 0) w = ($urandom_range(0, 3) != 0);
      else                    w = ($urandom_range(0, 3) == 0);
      ri = (m_rbin != m_wbin) && ($urandom_range(0, 1) == 1);
      c  = ($urandom_range(0, 7) == 0);
      step(w, c, ri ? (m_rbin + 1) % 32 : m_rbin, th);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
